// File: rtl/amcxrfif_rdsched_if.sv
// Bundle between the receive-FIFO read port, the two consumers and the read scheduler.
// slave = scheduler view, master = FIFO/consumer environment view.
interface amcxrfif_rdsched_if #(
  parameter int DW   = 32,
  parameter int CNTW = 16
);
  logic            frm_avail;
  logic [DW+3:0]   fifo_dat;
  logic            fifo_vld;
  logic            fifo_rd;
  logic [1:0]      req;
  logic [1:0]      drop;
  logic [1:0]      c_rdy;
  logic [1:0]      gnt;
  logic [1:0]      c_vld;
  logic [DW+3:0]   c_dat;
  logic            err_pls;
  logic [CNTW-1:0] drop_cnt;

  modport master (
    output frm_avail, fifo_dat, fifo_vld, req, drop, c_rdy,
    input  fifo_rd, gnt, c_vld, c_dat, err_pls, drop_cnt
  );

  modport slave (
    input  frm_avail, fifo_dat, fifo_vld, req, drop, c_rdy,
    output fifo_rd, gnt, c_vld, c_dat, err_pls, drop_cnt
  );
endinterface

// File: rtl/amcxrfif_rdsched.sv
// Frame-granular round-robin read scheduler for the receive FIFO (DMA = req 0, CPU = req 1).
// Define AMCXRFIF_RDSCHED_TMO_EN to add the consumer-stall timeout watchdog.
module amcxrfif_rdsched #(
  parameter int DW      = 32,
  parameter int TMO_CYC = 1024,
  parameter int CNTW    = 16
) (
  input  logic                CORETSE_AHBOlo,
  input  logic                CORETSE_AHBI0II,
  amcxrfif_rdsched_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_gnt;
  logic [1:0]      w_gnt_nxt;
  logic            r_rr_ptr;
  logic            w_rr_ptr_nxt;
  logic            r_first;
  logic            w_first_nxt;
  logic [CNTW-1:0] r_drop_cnt;
  logic [CNTW-1:0] w_drop_cnt_nxt;

  logic            w_g;
  logic            w_win;
  logic            w_sof;
  logic            w_eof;
  logic            w_fmt_err;
  logic            w_tmo;
  logic            w_fifo_rd;
  logic [1:0]      w_c_vld;
  logic            w_err;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (&v) return v;
    return v + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  assign w_sof = bus.fifo_dat[DW+3];
  assign w_eof = bus.fifo_dat[DW+2];

  // Grant is one-hot, so bit 1 alone identifies the owner.
  assign w_g   = r_gnt[1];
  assign w_win = bus.req[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;

  // A frame must open with SOF and never carry another one before EOF.
  assign w_fmt_err = bus.fifo_vld & (r_first ? ~w_sof : w_sof);

`ifdef AMCXRFIF_RDSCHED_TMO_EN
  logic [15:0] r_tmo_cnt;
  logic [15:0] w_tmo_cnt_nxt;
  logic        w_stall;

  assign w_stall = bus.fifo_vld & ~bus.c_rdy[w_g];
  assign w_tmo   = (r_state == XFER) & w_stall & (r_tmo_cnt == 16'(TMO_CYC - 1));

  always_comb begin
    w_tmo_cnt_nxt = r_tmo_cnt;
    if (r_state != XFER) begin
      w_tmo_cnt_nxt = 16'd0;
    end else if (w_fifo_rd) begin
      w_tmo_cnt_nxt = 16'd0;
    end else if (w_stall) begin
      w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge CORETSE_AHBOlo) begin
    if (CORETSE_AHBI0II) begin
      r_tmo_cnt <= 16'd0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_first_nxt    = r_first;
    w_drop_cnt_nxt = r_drop_cnt;
    w_fifo_rd      = 1'b0;
    w_c_vld        = 2'b00;
    w_err          = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.frm_avail && (|bus.req)) w_state_nxt = ARB;
      end

      ARB: begin
        if (|bus.req) begin
          w_gnt_nxt    = w_win ? 2'b10 : 2'b01;
          w_rr_ptr_nxt = ~w_win;
          w_first_nxt  = 1'b1;
          w_state_nxt  = XFER;
        end else begin
          w_state_nxt  = IDLE;
        end
      end

      XFER: begin
        if (w_fmt_err || w_tmo) begin
          w_err       = 1'b1;
          w_state_nxt = DRAIN;
        end else begin
          w_c_vld[w_g] = bus.fifo_vld;
          w_fifo_rd    = bus.fifo_vld & bus.c_rdy[w_g];
          if (w_fifo_rd) w_first_nxt = 1'b0;
          // An EOF pop completes the frame even if drop arrives in the same cycle.
          if (w_fifo_rd && w_eof) begin
            w_gnt_nxt   = 2'b00;
            w_state_nxt = GAP;
          end else if (bus.drop[w_g]) begin
            w_state_nxt = DRAIN;
          end
        end
      end

      DRAIN: begin
        w_fifo_rd = bus.fifo_vld;
        if (bus.fifo_vld && w_eof) begin
          w_drop_cnt_nxt = sat_inc(r_drop_cnt);
          w_gnt_nxt      = 2'b00;
          w_state_nxt    = GAP;
        end
      end

      GAP: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CORETSE_AHBOlo) begin
    if (CORETSE_AHBI0II) begin
      r_state    <= IDLE;
      r_gnt      <= 2'b00;
      r_rr_ptr   <= 1'b0;
      r_first    <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_first    <= w_first_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

  assign bus.fifo_rd  = w_fifo_rd;
  assign bus.c_vld    = w_c_vld;
  assign bus.c_dat    = bus.fifo_dat;
  assign bus.err_pls  = w_err;
  assign bus.gnt      = r_gnt;
  assign bus.drop_cnt = r_drop_cnt;

endmodule
